// File: rtl/uart_tx_fifo_pkg.sv
// Shared types for the UART transmit buffer.
// Holds the pacing FSM state encoding.
package uart_tx_fifo_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_LOW = 1'b1
  } tx_state_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// Byte storage for the UART transmit buffer.
// One write port, one combinational read port.
module uart_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit buffer between the port-0 write decode and tx_engine.
// Queues bytes and paces them out on the txrdy handshake.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [7:0]  din,
  input  logic        clr_ovf,
  input  logic        txrdy,
  output logic        tx_load,
  output logic [7:0]  tx_data,
  output logic        empty,
  output logic        full,
  output logic [AW:0] count,
  output logic        ovf
);

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  tx_state_e     state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          tx_load_q, tx_load_d;
  logic [7:0]    tx_data_q, tx_data_d;

  logic       pop;
  logic       accept;
  logic       drop;
  logic [7:0] rd_byte;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_FULL);

  // A pop frees a slot on the same edge, so a write into a full FIFO
  // is still accepted; storage reads the old entry before it is overwritten.
  assign pop    = (state_q == IDLE) && !empty && txrdy;
  assign accept = wr_en && (!full || pop);
  assign drop   = wr_en && !accept;

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (accept),
    .waddr (wr_ptr_q),
    .wdata (din),
    .raddr (rd_ptr_q),
    .rdata (rd_byte)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (accept) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    unique case ({accept, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    // A drop on the same edge as a clear leaves the flag set.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    tx_load_d = 1'b0;
    tx_data_d = tx_data_q;
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          tx_load_d = 1'b1;
          tx_data_d = rd_byte;
          state_d   = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (!txrdy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      tx_load_q <= 1'b0;
      tx_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      tx_load_q <= tx_load_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign tx_load = tx_load_q;
  assign tx_data = tx_data_q;
  assign count   = count_q;
  assign ovf     = ovf_q;

endmodule
